// File: rtl/bus_pkg.sv
// Shared constants and types for the RAM bus arbiter slice.
package bus_pkg;
    localparam int unsigned AW     = 16;
    localparam int unsigned DW     = 8;
    localparam int unsigned MIDX_W = 2;   // master index, enough for up to 4 masters
    localparam int unsigned OWN_W  = 3;
    localparam logic [OWN_W-1:0] OWN_CORE = '0;

    typedef enum logic {
        ST_CORE,
        ST_MASTER
    } own_state_e;
endpackage

// File: rtl/rr_pick.sv
// Round-robin request picker: lowest requesting index at or after ptr_i, wrapping to index 0.
module rr_pick
    import bus_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]   req_i,
    input  logic [MIDX_W-1:0] ptr_i,
    output logic              valid_o,
    output logic [MIDX_W-1:0] idx_o
);
    logic              hit_hi;
    logic [MIDX_W-1:0] idx_hi;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        hit_hi  = 1'b0;
        idx_hi  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_i[i] && !valid_o) begin
                valid_o = 1'b1;
                idx_o   = MIDX_W'(i);
            end
            if (req_i[i] && !hit_hi && (i >= 32'(ptr_i))) begin
                hit_hi = 1'b1;
                idx_hi = MIDX_W'(i);
            end
        end
        // a requester at or after the pointer beats the wrapped-around lowest one
        if (hit_hi) begin
            idx_o = idx_hi;
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// Shares the synchronous-RAM bus between the 65C02 core (default owner, stalled via RDY)
// and NREQ bus masters with round-robin selection and bounded hold time.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CPU_MIN  = 2
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [AW-1:0]      cpu_AD,
    input  logic [DW-1:0]      cpu_DO,
    input  logic               cpu_WE,
    output logic               cpu_RDY,
    output logic [DW-1:0]      cpu_DI,
    input  logic [NREQ-1:0]    m_req,
    input  logic [AW*NREQ-1:0] m_AD,
    input  logic [DW*NREQ-1:0] m_DO,
    input  logic [NREQ-1:0]    m_WE,
    output logic [NREQ-1:0]    m_gnt,
    output logic [NREQ-1:0]    m_rvalid,
    output logic [DW-1:0]      m_DI,
    output logic [AW-1:0]      mem_AD,
    output logic [DW-1:0]      mem_DO,
    output logic               mem_WE,
    input  logic [DW-1:0]      mem_DI
);
    localparam int unsigned CNT_W = $clog2(HOLD_MAX > CPU_MIN ? HOLD_MAX : CPU_MIN) + 1;

    own_state_e        state_q;
    logic [MIDX_W-1:0] midx_q;
    logic [MIDX_W-1:0] rr_q;
    logic [MIDX_W-1:0] rr_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  hold_q;
    logic              prev_core_q;
    logic [NREQ-1:0]   rvalid_q;

    logic              pick_valid;
    logic [MIDX_W-1:0] pick_idx;
    logic              master;
    logic              req_cur;
    logic              we_sel;
    logic [AW-1:0]     ad_sel;
    logic [DW-1:0]     do_sel;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i   (m_req),
        .ptr_i   (rr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign master = (state_q == ST_MASTER);

    always_comb begin
        req_cur = 1'b0;
        we_sel  = 1'b0;
        ad_sel  = '0;
        do_sel  = '0;
        m_gnt   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (midx_q == MIDX_W'(i)) begin
                req_cur  = m_req[i];
                we_sel   = m_WE[i] & m_req[i];
                ad_sel   = m_AD[AW*i +: AW];
                do_sel   = m_DO[DW*i +: DW];
                m_gnt[i] = master;
            end
        end
        rr_d = (32'(midx_q) == NREQ - 1) ? '0 : midx_q + MIDX_W'(1);
    end

    assign mem_AD   = master ? ad_sel : cpu_AD;
    assign mem_DO   = master ? do_sel : cpu_DO;
    assign mem_WE   = master ? we_sel : cpu_WE;
    // core only advances when its address is on the bus now and DI answers its last address
    assign cpu_RDY  = !master && prev_core_q;
    assign cpu_DI   = mem_DI;
    assign m_DI     = mem_DI;
    assign m_rvalid = rvalid_q;

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= ST_CORE;
            midx_q      <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            prev_core_q <= 1'b1;
            rvalid_q    <= '0;
        end else begin
            prev_core_q <= !master;
            rvalid_q    <= m_gnt & m_req;
            case (state_q)
                ST_CORE: begin
                    if (cnt_q >= CNT_W'(CPU_MIN - 1) && pick_valid) begin
                        state_q <= ST_MASTER;
                        midx_q  <= pick_idx;
                        cnt_q   <= '0;
                        hold_q  <= '0;
                    end else if (cnt_q < CNT_W'(CPU_MIN - 1)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_MASTER: begin
                    if (!req_cur || hold_q == CNT_W'(HOLD_MAX - 1)) begin
                        state_q <= ST_CORE;
                        cnt_q   <= '0;
                        rr_q    <= rr_d;
                    end else begin
                        hold_q <= hold_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_CORE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: per-cycle expectations queued by the driver, checked by a monitor.
module tb_bus_arbiter;
    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] cpu_AD;
    logic [7:0]  cpu_DO;
    logic        cpu_WE;
    logic        cpu_RDY;
    logic [7:0]  cpu_DI;
    logic [1:0]  m_req;
    logic [31:0] m_AD;
    logic [15:0] m_DO;
    logic [1:0]  m_WE;
    logic [1:0]  m_gnt;
    logic [1:0]  m_rvalid;
    logic [7:0]  m_DI;
    logic [15:0] mem_AD;
    logic [7:0]  mem_DO;
    logic        mem_WE;
    logic [7:0]  mem_DI;

    logic [7:0]  mem [0:65535];

    typedef struct {
        string       nm;
        logic        rdy;
        logic [1:0]  gnt;
        logic [1:0]  rv;
        logic        chk_bus;
        logic [15:0] ad;
        logic        we;
        logic [7:0]  dout;
        logic        chk_di;
        logic [7:0]  di;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    bus_arbiter #(.NREQ(2), .HOLD_MAX(8), .CPU_MIN(2)) dut (
        .clk      (clk),
        .RST      (RST),
        .cpu_AD   (cpu_AD),
        .cpu_DO   (cpu_DO),
        .cpu_WE   (cpu_WE),
        .cpu_RDY  (cpu_RDY),
        .cpu_DI   (cpu_DI),
        .m_req    (m_req),
        .m_AD     (m_AD),
        .m_DO     (m_DO),
        .m_WE     (m_WE),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_DI     (m_DI),
        .mem_AD   (mem_AD),
        .mem_DO   (mem_DO),
        .mem_WE   (mem_WE),
        .mem_DI   (mem_DI)
    );

    always #5 clk = ~clk;

    // synchronous RAM: write and read in the address cycle, data out the next cycle
    always @(posedge clk) begin
        if (mem_WE === 1'b1) mem[mem_AD] <= mem_DO;
        mem_DI <= mem[mem_AD];
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic bad;
            e = q.pop_front();
            vectors++;
            bad = (cpu_RDY !== e.rdy) || (m_gnt !== e.gnt) || (m_rvalid !== e.rv);
            if (e.chk_bus && ((mem_AD !== e.ad) || (mem_WE !== e.we) || (mem_DO !== e.dout))) bad = 1'b1;
            if (e.chk_di && ((m_DI !== e.di) || (cpu_DI !== e.di))) bad = 1'b1;
            if (bad) begin
                miscompares++;
                $display("FAIL %s: got rdy=%b gnt=%b rv=%b ad=%h we=%b do=%h di=%h / want rdy=%b gnt=%b rv=%b ad=%h we=%b do=%h di=%h (bus %b, di %b)",
                         e.nm, cpu_RDY, m_gnt, m_rvalid, mem_AD, mem_WE, mem_DO, m_DI,
                         e.rdy, e.gnt, e.rv, e.ad, e.we, e.dout, e.di, e.chk_bus, e.chk_di);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_exp(input string nm, input logic rdy, input logic [1:0] rv);
        exp_t e;
        e.nm = nm; e.rdy = rdy; e.gnt = 2'b00; e.rv = rv;
        e.chk_bus = 1'b1; e.ad = cpu_AD; e.we = cpu_WE; e.dout = cpu_DO;
        e.chk_di = 1'b0; e.di = 8'h00;
        q.push_back(e);
    endtask

    task automatic mst_exp(input string nm, input int idx, input logic [1:0] rv,
                           input logic [15:0] ad, input logic we, input logic [7:0] dout,
                           input logic cd, input logic [7:0] di);
        exp_t e;
        e.nm = nm; e.rdy = 1'b0; e.gnt = (idx == 0) ? 2'b01 : 2'b10; e.rv = rv;
        e.chk_bus = 1'b1; e.ad = ad; e.we = we; e.dout = dout;
        e.chk_di = cd; e.di = di;
        q.push_back(e);
    endtask

    task automatic final_check(input string nm, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    initial begin
        int ph;
        RST = 1'b1; cpu_AD = 16'h1000; cpu_DO = 8'h00; cpu_WE = 1'b0;
        m_req = 2'b00; m_AD = '0; m_DO = '0; m_WE = 2'b00;
        mem[16'h2000] = 8'hA1; mem[16'h2001] = 8'hB2; mem[16'h2002] = 8'hC3;
        mem[16'h0200] = 8'h00; mem[16'h2100] = 8'h00;

        tick(); core_exp("reset", 1'b1, 2'b00); RST = 1'b0;

        // idle fetch loop
        for (int k = 0; k < 6; k++) begin
            tick(); cpu_AD = 16'h1000 + 16'(k); core_exp($sformatf("idle%0d", k), 1'b1, 2'b00);
        end

        // single master, three reads
        tick(); m_req = 2'b01; m_AD[15:0] = 16'h2000; core_exp("t2_req", 1'b1, 2'b00);
        tick(); mst_exp("t2_g0", 0, 2'b00, 16'h2000, 1'b0, 8'h00, 1'b0, 8'h00);
        tick(); m_AD[15:0] = 16'h2001; mst_exp("t2_g1", 0, 2'b01, 16'h2001, 1'b0, 8'h00, 1'b1, 8'hA1);
        tick(); m_AD[15:0] = 16'h2002; mst_exp("t2_g2", 0, 2'b01, 16'h2002, 1'b0, 8'h00, 1'b1, 8'hB2);
        tick(); m_req = 2'b00; mst_exp("t2_drop", 0, 2'b01, 16'h2002, 1'b0, 8'h00, 1'b1, 8'hC3);
        tick(); core_exp("t2_reissue", 1'b0, 2'b00);
        tick(); core_exp("t2_run", 1'b1, 2'b00);

        // hog on master 1
        tick(); m_req = 2'b10; m_AD[31:16] = 16'h3000; core_exp("t3_req", 1'b1, 2'b00);
        for (int p = 0; p < 30; p++) begin
            tick(); ph = p % 10;
            if (ph < 8) mst_exp($sformatf("t3_p%0d", p), 1, (ph >= 1) ? 2'b10 : 2'b00, 16'h3000, 1'b0, 8'h00, 1'b0, 8'h00);
            else        core_exp($sformatf("t3_p%0d", p), ph == 9, (ph == 8) ? 2'b10 : 2'b00);
        end
        tick(); m_req = 2'b00; mst_exp("t3_drop", 1, 2'b00, 16'h3000, 1'b0, 8'h00, 1'b0, 8'h00);
        tick(); core_exp("t3_reissue", 1'b0, 2'b00);
        tick(); core_exp("t3_run", 1'b1, 2'b00);

        // contention: alternate masters with core slots between
        tick(); m_req = 2'b11; m_AD = {16'h3000, 16'h2000}; core_exp("t4_req", 1'b1, 2'b00);
        for (int p = 0; p < 40; p++) begin
            tick(); ph = p % 20;
            if (ph < 8)       mst_exp($sformatf("t4_p%0d", p), 0, (ph >= 1) ? 2'b01 : 2'b00, 16'h2000, 1'b0, 8'h00, 1'b0, 8'h00);
            else if (ph < 10) core_exp($sformatf("t4_p%0d", p), ph == 9, (ph == 8) ? 2'b01 : 2'b00);
            else if (ph < 18) mst_exp($sformatf("t4_p%0d", p), 1, (ph >= 11) ? 2'b10 : 2'b00, 16'h3000, 1'b0, 8'h00, 1'b0, 8'h00);
            else              core_exp($sformatf("t4_p%0d", p), ph == 19, (ph == 18) ? 2'b10 : 2'b00);
        end
        tick(); m_req = 2'b00; mst_exp("t4_drop", 0, 2'b00, 16'h2000, 1'b0, 8'h00, 1'b0, 8'h00);
        tick(); core_exp("t4_reissue", 1'b0, 2'b00);
        tick(); core_exp("t4_run", 1'b1, 2'b00);

        // core write pending while a writing master owns the bus
        tick(); m_req = 2'b01; m_AD[15:0] = 16'h2100; m_DO[7:0] = 8'h77; m_WE = 2'b01; cpu_AD = 16'h1234;
        core_exp("t5_A", 1'b1, 2'b00);
        tick(); cpu_AD = 16'h0200; cpu_DO = 8'h55; cpu_WE = 1'b1;
        mst_exp("t5_B", 0, 2'b00, 16'h2100, 1'b1, 8'h77, 1'b0, 8'h00);
        tick(); mst_exp("t5_C", 0, 2'b01, 16'h2100, 1'b1, 8'h77, 1'b0, 8'h00);
        tick(); mst_exp("t5_D", 0, 2'b01, 16'h2100, 1'b1, 8'h77, 1'b0, 8'h00);
        tick(); m_req = 2'b00; mst_exp("t5_E_dropwe", 0, 2'b01, 16'h2100, 1'b0, 8'h77, 1'b0, 8'h00);
        tick(); core_exp("t5_F_wr1", 1'b0, 2'b00);
        tick(); core_exp("t5_G_wr2", 1'b1, 2'b00);

        // reset in the middle of a master-1 grant (hold count 3)
        tick(); cpu_WE = 1'b0; cpu_AD = 16'h1000; m_req = 2'b10; m_AD[31:16] = 16'h3000; m_WE = 2'b00;
        core_exp("t6_req", 1'b1, 2'b00);
        tick(); mst_exp("t6_h0", 1, 2'b00, 16'h3000, 1'b0, 8'h00, 1'b0, 8'h00);
        tick(); mst_exp("t6_h1", 1, 2'b10, 16'h3000, 1'b0, 8'h00, 1'b0, 8'h00);
        tick(); mst_exp("t6_h2", 1, 2'b10, 16'h3000, 1'b0, 8'h00, 1'b0, 8'h00);
        tick(); RST = 1'b1; mst_exp("t6_h3", 1, 2'b10, 16'h3000, 1'b0, 8'h00, 1'b0, 8'h00);
        tick(); RST = 1'b0; m_req = 2'b00; core_exp("t6_reset", 1'b1, 2'b00);
        tick(); core_exp("t6_after", 1'b1, 2'b00);

        tick(); tick();
        final_check("mem_0200", mem[16'h0200], 8'h55);
        final_check("mem_2100", mem[16'h2100], 8'h77);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d pending want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
